// File: rtl/sockit_spi_rdr.sv
// ---------------------------------------------------------------------------
// sockit_spi_rdr
// AXI4-Lite read-side responder for SPI receive data. Words from the SPI
// read-data stream are buffered in a small FIFO. Four read addresses deliver
// them to the bus:
//   ARADDR[3:2] = 0 : blocking pop (waits up to TMO cycles on an empty FIFO)
//   ARADDR[3:2] = 1 : status {16'b0, count[7:0], 6'b0, full, empty}
//   ARADDR[3:2] = 2 : peek head word (0 when empty), no pop
//   ARADDR[3:2] = 3 : flush, returns the count before the flush
// Only the AR and R channels live here.
//
// Handshake rule: a transfer happens on a rising ACLK edge when valid and
// ready are both high; a source holds valid and payload stable until then.
//
// Ports
//   ACLK, ARESETn      clock, asynchronous active-low reset
//   ARVALID/ARREADY    read address handshake, ARADDR[3:2] decoded
//   RVALID/RREADY      read data handshake, RDATA/RRESP payload
//   srd_vld/srd_rdy    SPI read-data stream handshake, srd_dat payload
//   irq                high while the FIFO holds data
//   o_dbg_state        current FSM state (0 idle, 1 wait, 2 resp)
// ---------------------------------------------------------------------------
module sockit_spi_rdr #(
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   parameter int TMO   = 256
) (
   input  logic          ACLK,
   input  logic          ARESETn,
   input  logic          ARVALID,
   output logic          ARREADY,
   input  logic [3:0]    ARADDR,
   output logic          RVALID,
   input  logic          RREADY,
   output logic [DW-1:0] RDATA,
   output logic [1:0]    RRESP,
   input  logic          srd_vld,
   input  logic [DW-1:0] srd_dat,
   output logic          srd_rdy,
   output logic          irq,
   output logic [1:0]    o_dbg_state
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [DW-1:0]   r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [15:0]     r_tmo_cnt;
   logic            r_arready;
   logic            r_rvalid;
   logic [DW-1:0]   r_rdata;
   logic [1:0]      r_rresp;

   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_flush;
   logic            w_ar_hs;
   logic            w_r_hs;
   logic            w_tmo_hit;
   logic            w_tmo_clr;
   logic            w_load;
   logic [DW-1:0]   w_rdata_nxt;
   logic [1:0]      w_rresp_nxt;
   logic [DW-1:0]   w_head;
   logic [DW-1:0]   w_status;
   logic            w_unused_addr;

   assign w_full        = (r_count == CW'(DEPTH));
   assign w_empty       = (r_count == '0);
   assign w_head        = r_mem[r_rptr];
   assign w_push        = srd_vld & ~w_full;
   assign w_ar_hs       = ARVALID & r_arready;
   assign w_r_hs        = r_rvalid & RREADY;
   assign w_unused_addr = ^ARADDR[1:0];

   // Timeout fires in the WAIT cycle whose counter equals TMO-1; TMO=0 never fires.
   assign w_tmo_hit = (TMO != 0) && (r_tmo_cnt == 16'(TMO - 1));

   always_comb begin
      w_status      = '0;
      w_status[15:8] = 8'(r_count);
      w_status[1]   = w_full;
      w_status[0]   = w_empty;
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_ar_hs) begin
               if ((ARADDR[3:2] == 2'd0) && w_empty) w_state_nxt = ST_WAIT;
               else                                  w_state_nxt = ST_RESP;
            end
         end
         ST_WAIT: begin
            if (!w_empty || w_tmo_hit) w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (w_r_hs) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (FIFO control and the response to load)
   // ------------------------------------------------------------------
   always_comb begin
      w_pop       = 1'b0;
      w_flush     = 1'b0;
      w_load      = 1'b0;
      w_tmo_clr   = 1'b0;
      w_rdata_nxt = '0;
      w_rresp_nxt = RESP_OKAY;
      case (r_state)
         ST_IDLE: begin
            if (w_ar_hs) begin
               case (ARADDR[3:2])
                  2'd0: begin
                     if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_load      = 1'b1;
                        w_rdata_nxt = w_head;
                     end else begin
                        w_tmo_clr   = 1'b1;
                     end
                  end
                  2'd1: begin
                     w_load      = 1'b1;
                     w_rdata_nxt = w_status;
                  end
                  2'd2: begin
                     w_load      = 1'b1;
                     w_rdata_nxt = w_empty ? '0 : w_head;
                  end
                  default: begin
                     w_load      = 1'b1;
                     w_flush     = 1'b1;
                     w_rdata_nxt = DW'(r_count);
                  end
               endcase
            end
         end
         ST_WAIT: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_load      = 1'b1;
               w_rdata_nxt = w_head;
            end else if (w_tmo_hit) begin
               w_load      = 1'b1;
               w_rresp_nxt = RESP_SLVERR;
            end
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // FIFO storage and pointers. A flush wins over a same-cycle push, so the
   // pushed word is accepted on the stream and then discarded.
   // ------------------------------------------------------------------
   always_ff @(posedge ACLK) begin
      if (w_push) r_mem[r_wptr] <= srd_dat;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (w_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // ------------------------------------------------------------------
   // Blocking-pop timeout counter
   // ------------------------------------------------------------------
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn)                 r_tmo_cnt <= '0;
      else if (w_tmo_clr)           r_tmo_cnt <= '0;
      else if (r_state == ST_WAIT)  r_tmo_cnt <= r_tmo_cnt + 16'd1;
   end

   // ------------------------------------------------------------------
   // Registered bus outputs. ARREADY/RVALID follow the next state so they
   // change on the same edge as the FSM; RDATA/RRESP stay frozen in RESP.
   // ------------------------------------------------------------------
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_arready <= (w_state_nxt == ST_IDLE);
         r_rvalid  <= (w_state_nxt == ST_RESP);
         if (w_load) begin
            r_rdata <= w_rdata_nxt;
            r_rresp <= w_rresp_nxt;
         end
      end
   end

   assign ARREADY     = r_arready;
   assign RVALID      = r_rvalid;
   assign RDATA       = r_rdata;
   assign RRESP       = r_rresp;
   assign srd_rdy     = ~w_full;
   assign irq         = ~w_empty;
   assign o_dbg_state = r_state;

endmodule
